// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   nop_instr       : canonical RV32 nop (addi x0, x0, 0)
//   fetch_state_e   : request FSM encoding
//   fetch_out_type  : bundle presented to decode
//   fetch_reg_type  : architectural state of the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] nop_instr = 32'h00000013;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        valid;
  } fetch_out_type;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  faddr;
    logic         skip_low;
    fetch_state_e state;
    logic         imem_valid;
    logic [31:0]  imem_addr;
  } fetch_reg_type;

endpackage

// File: rtl/fetch_queue.sv
// Halfword FIFO between instruction memory and decode presentation.
//   clock, reset     : clock, asynchronous active-high reset
//   flush            : empty the queue (overrides push and pop)
//   push_n           : 0/1/2 halfwords written; push_lo lands first
//   push_lo, push_hi : halfwords to write
//   pop_n            : 0/1/2 halfwords removed from the head
//   count            : current occupancy
//   head0, head1     : oldest and second-oldest entries
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [1:0]             push_n,
  input  logic [15:0]            push_lo,
  input  logic [15:0]            push_hi,
  input  logic [1:0]             pop_n,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            head0,
  output logic [15:0]            head1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_nxt, wr_nxt;
  logic [CW-1:0] count_q;

  // Power-of-two depth: pointer arithmetic wraps naturally.
  assign rd_nxt = rd_q + 1'b1;
  assign wr_nxt = wr_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_q + AW'(pop_n);
      wr_q    <= wr_q + AW'(push_n);
      count_q <= count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clock) begin
    if (!flush && push_n != 2'd0) mem_q[wr_q] <= push_lo;
    if (!flush && push_n == 2'd2) mem_q[wr_nxt] <= push_hi;
  end

  assign count = count_q;
  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[rd_nxt];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word requests to instruction memory, realigns
// returned words into RVC/RV32 instructions via a halfword queue and presents
// one instruction per cycle to decode.
//   clock, reset             : clock, asynchronous active-high reset
//   imem_valid, imem_addr    : one-cycle request strobe and word address
//   imem_ready, imem_rdata   : response strobe and data (one per request)
//   redirect, redirect_pc    : flush and restart at redirect_pc (bit0 ignored)
//   stall                    : decode cannot take the presented instruction
//   f_valid, f_pc, f_instr   : presented instruction and its pc
//   f_npc                    : pc of the sequentially following instruction
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int unsigned FQ_DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [31:0] f_npc
);

  import fetch_stage_pkg::*;

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_reg_type r_q, r_d;
  fetch_out_type fo;

  logic [CW-1:0] count, free, free_after;
  logic [15:0]   head0, head1, push_lo;
  logic [1:0]    push_n, pop_n;
  logic          head_rvc, consume, accept, issue;

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_queue (
    .clock  (clock),
    .reset  (reset),
    .flush  (redirect),
    .push_n (push_n),
    .push_lo(push_lo),
    .push_hi(imem_rdata[31:16]),
    .pop_n  (pop_n),
    .count  (count),
    .head0  (head0),
    .head1  (head1)
  );

  // Presentation and queue handshakes.
  always_comb begin
    head_rvc = head0[1:0] != 2'b11;
    fo.valid = !redirect && (head_rvc ? (count != '0) : (count >= CW'(2)));
    fo.pc    = r_q.pc;
    if (!fo.valid) begin
      fo.instr = nop_instr;
    end else if (head_rvc) begin
      fo.instr = {16'h0000, head0};
    end else begin
      fo.instr = {head1, head0};
    end
    fo.npc     = r_q.pc + ((fo.instr[1:0] != 2'b11) ? 32'd2 : 32'd4);
    consume    = fo.valid && !stall;
    pop_n      = consume ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    accept     = (r_q.state == StWait) && imem_ready && !redirect;
    // An odd restart address drops the low half of the first word.
    push_n     = accept ? (r_q.skip_low ? 2'd1 : 2'd2) : 2'd0;
    push_lo    = r_q.skip_low ? imem_rdata[31:16] : imem_rdata[15:0];
    // Free space ignores this cycle's pops so an issued word always fits.
    free       = CW'(FQ_DEPTH) - count;
    free_after = free - CW'(push_n);
  end

  // Next-state: request FSM, pc advance, redirect override.
  always_comb begin
    r_d            = r_q;
    r_d.imem_valid = 1'b0;
    issue          = 1'b0;
    if (consume) r_d.pc = r_q.pc + (head_rvc ? 32'd2 : 32'd4);
    unique case (r_q.state)
      StIdle: issue = !redirect && (free >= CW'(2));
      StWait: begin
        if (imem_ready) begin
          r_d.skip_low = 1'b0;
          r_d.state    = StIdle;
          issue        = !redirect && (free_after >= CW'(2));
        end else if (redirect) begin
          r_d.state = StDrop;
        end
      end
      StDrop: if (imem_ready) r_d.state = StIdle;
      default: r_d.state = StIdle;
    endcase
    if (issue) begin
      r_d.imem_valid = 1'b1;
      r_d.imem_addr  = r_q.faddr;
      r_d.faddr      = r_q.faddr + 32'd4;
      r_d.state      = StWait;
    end
    if (redirect) begin
      r_d.pc       = {redirect_pc[31:1], 1'b0};
      r_d.faddr    = {redirect_pc[31:2], 2'b00};
      r_d.skip_low = redirect_pc[1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q.pc         <= RESET_VECTOR;
      r_q.faddr      <= {RESET_VECTOR[31:2], 2'b00};
      r_q.skip_low   <= RESET_VECTOR[1];
      r_q.state      <= StIdle;
      r_q.imem_valid <= 1'b0;
      r_q.imem_addr  <= 32'h0;
    end else begin
      r_q <= r_d;
    end
  end

  assign imem_valid = r_q.imem_valid;
  assign imem_addr  = r_q.imem_addr;
  assign f_valid    = fo.valid;
  assign f_pc       = fo.pc;
  assign f_instr    = fo.instr;
  assign f_npc      = fo.npc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RV    = 32'h00000100;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic [31:0] f_pc, f_instr, f_npc;

  always #5 clock = ~clock;

  fetch_stage #(
    .RESET_VECTOR(RV),
    .FQ_DEPTH    (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .f_npc      (f_npc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
  } rec_t;

  logic [31:0] mem [1024];
  int          total = 0;
  int          bad = 0;

  // Observed history, filled by the checker.
  rec_t        log_q[$];
  logic [31:0] req_q[$];
  rec_t        rec;

  // Responder control.
  int          min_delay = 1;
  int          max_delay = 1;
  bit          pend = 0;
  int          cd = 0;
  logic [31:0] paddr;
  bit          redir_on_resp = 0;
  bit          resp_redir_active = 0;
  logic [31:0] resp_redir_pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within bound at %0t", name, $time);
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Program-order view: the instruction that lives at address a.
  function automatic logic [31:0] model_instr(input logic [31:0] a);
    logic [15:0] lo, hi;
    lo = half_at(a);
    hi = half_at(a + 32'd2);
    return (lo[1:0] == 2'b11) ? {hi, lo} : {16'h0000, lo};
  endfunction

  // Memory responder: exactly one response per request after a random delay.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      imem_ready = 1'b0;
      if (resp_redir_active) begin
        redirect          = 1'b0;
        resp_redir_active = 0;
      end
      if (reset) begin
        pend = 0;
      end else if (pend) begin
        cd--;
        if (cd <= 0) begin
          imem_ready = 1'b1;
          imem_rdata = mem[paddr[11:2]];
          pend       = 0;
          if (redir_on_resp) begin
            redirect          = 1'b1;
            redirect_pc       = resp_redir_pc;
            redir_on_resp     = 0;
            resp_redir_active = 1;
          end
        end
      end else if (imem_valid) begin
        pend  = 1;
        paddr = imem_addr;
        cd    = $urandom_range(max_delay, min_delay);
      end
    end
  end

  // Behavioural model and per-cycle compare.
  logic [31:0] mpc, mfaddr, want_instr, want_npc;
  bit          outstanding, redir_prev;
  int          idle_run;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mpc         = RV;
        mfaddr      = {RV[31:2], 2'b00};
        outstanding = 0;
        redir_prev  = 0;
        idle_run    = 0;
      end else begin
        if (redir_prev) check("no_req_after_redirect", imem_valid, 1'b0);
        if (imem_valid) begin
          check("req_addr", imem_addr, mfaddr);
          check("single_outstanding", outstanding, 1'b0);
          req_q.push_back(imem_addr);
          mfaddr      = mfaddr + 32'd4;
          outstanding = 1;
        end
        if (imem_ready) outstanding = 0;
        if (redirect) check("mask_on_redirect", f_valid, 1'b0);
        if (f_valid) begin
          want_instr = model_instr(mpc);
          want_npc   = mpc + ((want_instr[1:0] == 2'b11) ? 32'd4 : 32'd2);
          check("f_pc", f_pc, mpc);
          check("f_instr", f_instr, want_instr);
          check("f_npc", f_npc, want_npc);
          if (!stall) begin
            rec.pc    = f_pc;
            rec.instr = f_instr;
            rec.npc   = f_npc;
            log_q.push_back(rec);
            mpc = want_npc;
          end
          idle_run = 0;
        end else begin
          check("nop_when_invalid", f_instr, NOP);
          idle_run++;
          if (idle_run > 40) begin
            fail_now("liveness_f_valid");
            idle_run = 0;
          end
        end
        if (redirect) begin
          mpc    = {redirect_pc[31:1], 1'b0};
          mfaddr = {redirect_pc[31:2], 2'b00};
        end
        redir_prev = redirect;
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_f_valid", f_valid, 1'b0);
    check("rst_f_instr", f_instr, NOP);
    check("rst_f_pc", f_pc, RV);
    check("rst_imem_valid", imem_valid, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    log_q.delete();
    req_q.delete();
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] d_pc [6] = '{32'h100, 32'h104, 32'h106, 32'h108, 32'h10A, 32'h10E};
  logic [31:0] d_in [6] = '{32'h00500093, 32'h00004501, 32'h00004581,
                            32'h00004505, 32'hA0020093, 32'h00004505};
  logic [31:0] d_np [6] = '{32'h104, 32'h106, 32'h108, 32'h10A, 32'h10E, 32'h110};

  initial begin
    bit seen;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;

    // Directed program: 32-bit, two RVC, RVC + straddling 32-bit, RVC.
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
    mem[32'h100 >> 2] = 32'h00500093;
    mem[32'h104 >> 2] = 32'h45814501;
    mem[32'h108 >> 2] = 32'h00934505;
    mem[32'h10C >> 2] = 32'h4505A002;
    mem[32'h200 >> 2] = 32'h4509FFFF;
    min_delay = 1;
    max_delay = 1;
    do_reset();
    repeat (30) @(posedge clock);
    check("first_req_addr", req_q[0], 32'h100);
    for (int i = 0; i < 6; i++) begin
      check("dir_pc", log_q[i].pc, d_pc[i]);
      check("dir_instr", log_q[i].instr, d_in[i]);
      check("dir_npc", log_q[i].npc, d_np[i]);
    end

    // Redirect to an odd-halfword address while a request is outstanding.
    min_delay = 3;
    max_delay = 3;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clock);
      #1;
      seen = imem_valid;
    end
    if (!seen) fail_now("wait_request");
    @(posedge clock);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    log_q.delete();
    req_q.delete();
    @(posedge clock);
    #1;
    redirect = 1'b0;
    repeat (20) @(posedge clock);
    check("redir_req_addr", req_q[0], 32'h200);
    check("redir_first_pc", log_q[0].pc, 32'h202);
    check("redir_first_instr", log_q[0].instr, 32'h00004509);
    check("redir_first_npc", log_q[0].npc, 32'h204);

    // Fill under stall, then drain.
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    min_delay = 1;
    max_delay = 1;
    do_reset();
    stall = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("fill_req_count", req_q.size(), DEPTH / 2);
    check("fill_f_valid", f_valid, 1'b1);
    check("fill_f_pc", f_pc, RV);
    stall = 1'b0;
    repeat (60) @(posedge clock);
    check("drain_first_pc", log_q[0].pc, RV);

    // Redirect coincides with a response and a would-be consume.
    #1;
    stall = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    resp_redir_pc = 32'h300;
    redir_on_resp = 1;
    stall         = 1'b0;
    seen          = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clock);
      #3;
      seen = !redir_on_resp;
    end
    if (!seen) fail_now("wait_resp_redirect");
    check("coinc_mask", f_valid, 1'b0);
    log_q.delete();
    req_q.delete();
    repeat (20) @(posedge clock);
    check("coinc_req_addr", req_q[0], 32'h300);
    check("coinc_first_pc", log_q[0].pc, 32'h300);

    // Randomized traffic against the model.
    min_delay = 1;
    max_delay = 3;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #1;
      stall    = ($urandom_range(9, 0) < 3);
      redirect = ($urandom_range(39, 0) == 0);
      if (redirect) redirect_pc = $urandom & 32'h00000FFF;
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (10) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
